// File: rtl/vector_hsum_seq_if.sv
// Handshake/data bundle between the vector producer, the horizontal-sum stage and its consumer.
// master = upstream producer plus downstream consumer (testbench side); slave = the sum stage.
interface vector_hsum_seq_if #(
  parameter int ID_W = 8
);
  logic            new_data;
  logic [95:0]     v;
  logic [ID_W-1:0] id;
  logic            in_ready;
  logic            output_valid;
  logic            out_ready;
  logic [31:0]     r;
  logic [ID_W-1:0] r_id;
  logic            r_sat;
  logic            drop_err;

  modport master (
    output new_data, v, id, out_ready,
    input  in_ready, output_valid, r, r_id, r_sat, drop_err
  );

  modport slave (
    input  new_data, v, id, out_ready,
    output in_ready, output_valid, r, r_id, r_sat, drop_err
  );
endinterface

// File: rtl/vector_hsum_seq.sv
// Saturating sum of three Q16.16 components, tagged and buffered in a show-ahead FIFO.
// Sample edge N -> output_valid after edge N+2; results arriving at a full FIFO without a pop are dropped (sticky drop_err).
module vector_hsum_seq #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  vector_hsum_seq_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            sat;
    logic [31:0]     r;
  } entry_t;

  logic               r_valid1;
  logic signed [32:0] r_p;
  logic signed [31:0] r_q;
  logic [ID_W-1:0]    r_id1;
  logic               r_valid2;
  entry_t             r_ent2;
  entry_t             r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_drop_err;

  logic signed [32:0] w_p;
  logic signed [33:0] w_s;
  entry_t             w_ent;
  entry_t             w_head;
  logic               w_vld;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [CW:0]        w_occupancy;

  // Widths grow one bit per add so nothing wraps before the final saturation.
  assign w_p = {bus.v[31], bus.v[31:0]} + {bus.v[63], bus.v[63:32]};
  assign w_s = {r_p[32], r_p} + {{2{r_q[31]}}, r_q};

  always_comb begin
    w_ent.id  = r_id1;
    w_ent.sat = 1'b0;
    w_ent.r   = w_s[31:0];
    // In range exactly when the top three bits agree.
    if (w_s[33:31] != 3'b000 && w_s[33:31] != 3'b111) begin
      w_ent.sat = 1'b1;
      w_ent.r   = w_s[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  assign w_vld       = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = w_vld & bus.out_ready;
  assign w_push      = r_valid2 & (~w_full | w_pop);
  assign w_occupancy = (CW+1)'(r_count) + (CW+1)'(r_valid1) + (CW+1)'(r_valid2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid1   <= 1'b0;
      r_valid2   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_valid1 <= bus.new_data;
      r_valid2 <= r_valid1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (r_valid2 && !w_push) r_drop_err <= 1'b1;
    end
  end

  // Datapath and storage carry no reset; the output mux hides stale contents.
  always_ff @(posedge clk) begin
    r_p    <= w_p;
    r_q    <= bus.v[95:64];
    r_id1  <= bus.id;
    r_ent2 <= w_ent;
    if (w_push) r_mem[r_wr_ptr] <= r_ent2;
  end

  assign w_head           = w_vld ? r_mem[r_rd_ptr] : '0;
  assign bus.output_valid = w_vld;
  assign bus.r            = w_head.r;
  assign bus.r_id         = w_head.id;
  assign bus.r_sat        = w_head.sat;
  assign bus.drop_err     = r_drop_err;
  assign bus.in_ready     = (w_occupancy < (CW+1)'(DEPTH));
endmodule

// File: tb/tb_vector_hsum_seq.sv
// Scoreboard bench for vector_hsum_seq: expected results queued at drive time, compared at pop.
module tb_vector_hsum_seq;
  typedef struct packed {
    logic [31:0] r;
    logic [7:0]  id;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  vector_hsum_seq_if #(.ID_W(8)) bus();

  vector_hsum_seq #(.ID_W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [95:0] vv, input logic [7:0] tid);
    exp_t   e;
    longint s;
    s = longint'($signed(vv[31:0])) + longint'($signed(vv[63:32])) + longint'($signed(vv[95:64]));
    e.id = tid;
    e.sat = 1'b0;
    if (s > 64'sh7FFF_FFFF) begin
      e.r = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (s < -64'sh8000_0000) begin
      e.r = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.r = 32'(s);
    end
    return e;
  endfunction

  // Drive one input cycle's worth of stimulus; queue the expected result when it should survive.
  task automatic drive(input logic nd, input logic [95:0] vv, input logic [7:0] tid, input logic keep);
    bus.new_data = nd;
    bus.v = vv;
    bus.id = tid;
    if (nd && keep) exp_q.push_back(model(vv, tid));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.output_valid, bus.in_ready, bus.drop_err, bus.r_sat} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_flags got ov/ir/de/sat=%b want 0100",
               {bus.output_valid, bus.in_ready, bus.drop_err, bus.r_sat});
    end
    total++;
    if ({bus.r, bus.r_id} !== 40'h0) begin
      bad++; $display("FAIL reset_data got r=%h id=%h want 0", bus.r, bus.r_id);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t got;
    exp_t e;
    bus.out_ready = 1'b1;
    drive(1'b1, {32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 8'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (bus.output_valid !== 1'b0) begin
        bad++; $display("FAIL basic_early k=%0d got ov=%b want 0", k, bus.output_valid);
      end
      tick();
    end
    got = {bus.r, bus.r_id, bus.r_sat};
    total++;
    if (bus.output_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL basic_valid got ov=%b want 1", bus.output_valid);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++; $display("FAIL basic_data got %h want %h", got, e);
      end
    end
    tick();
    total++;
    if (bus.output_valid !== 1'b0) begin
      bad++; $display("FAIL basic_popped got ov=%b want 0", bus.output_valid);
    end
  endtask

  task automatic test_arith();
    logic [95:0] vecs [4];
    exp_t got;
    exp_t e;
    vecs[0] = {32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_0000};
    vecs[1] = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[2] = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = {32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(1'b1, vecs[c], 8'(20 + c), 1'b1);
      else       drive(1'b0, '0, '0, 1'b0);
      if (bus.output_valid) begin
        got = {bus.r, bus.r_id, bus.r_sat};
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        total++;
        if (got !== e) begin
          bad++; $display("FAIL arith_result got %h want %h", got, e);
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL arith_drain got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    exp_t got;
    exp_t e;
    logic [31:0] c0, c1, c2;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      c0 = ($urandom_range(0, 2) == 0) ? 32'h7FFF_FF00 : $urandom;
      c1 = ($urandom_range(0, 2) == 0) ? 32'h8000_0100 : $urandom;
      c2 = $urandom;
      if (c < 10) drive(1'b1, {c2, c1, c0}, 8'(60 + c), 1'b1);
      else        drive(1'b0, '0, '0, 1'b0);
      if (bus.output_valid) begin
        got = {bus.r, bus.r_id, bus.r_sat};
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        total++;
        if (got !== e) begin
          bad++; $display("FAIL random_result got %h want %h", got, e);
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL random_drain got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // FIFO fills while out_ready is low, then push and pop coincide on a full FIFO.
  task automatic test_back_to_back();
    exp_t got;
    exp_t e;
    int   pops = 0;
    for (int k = 0; k < 24; k++) begin
      if (k < 14) drive(1'b1, {$urandom, $urandom, $urandom}, 8'(40 + k), 1'b1);
      else        drive(1'b0, '0, '0, 1'b0);
      bus.out_ready = (k >= 6);
      total++;
      if (bus.output_valid !== (k >= 3 && k <= 19)) begin
        bad++; $display("FAIL b2b_valid k=%0d got ov=%b want %b", k, bus.output_valid, (k >= 3 && k <= 19));
      end
      if (bus.output_valid && bus.out_ready) begin
        got = {bus.r, bus.r_id, bus.r_sat};
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        pops++;
        total++;
        if (got !== e) begin
          bad++; $display("FAIL b2b_result got %h want %h", got, e);
        end
      end
      tick();
    end
    total++;
    if (pops != 14 || bus.drop_err !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_summary got pops=%0d drop=%b left=%0d want 14/0/0", pops, bus.drop_err, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    exp_t got;
    exp_t e;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, {32'h0001_0000, 32'(k), 32'(k)}, 8'(k), k < 4);
      tick();
      total++;
      if (bus.in_ready !== (k < 3)) begin
        bad++; $display("FAIL ovf_in_ready k=%0d got %b want %b", k, bus.in_ready, (k < 3));
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    tick();
    total++;
    if ({bus.drop_err, bus.output_valid, bus.in_ready} !== 3'b110) begin
      bad++; $display("FAIL ovf_state got de/ov/ir=%b want 110", {bus.drop_err, bus.output_valid, bus.in_ready});
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = {bus.r, bus.r_id, bus.r_sat};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      total++;
      if (bus.output_valid !== 1'b1 || got !== e) begin
        bad++; $display("FAIL ovf_drain i=%0d got ov=%b %h want 1 %h", i, bus.output_valid, got, e);
      end
      tick();
    end
    total++;
    if (bus.output_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_empty got ov=%b want 0", bus.output_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, {32'h0000_1000, 32'h0000_2000, 32'h0000_3000}, 8'(90 + k), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    total++;
    if (bus.output_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got ov=%b want 1", bus.output_valid);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    total++;
    if ({bus.output_valid, bus.drop_err, bus.in_ready} !== 3'b001 || bus.r !== 32'h0) begin
      bad++; $display("FAIL midrst_state got ov/de/ir=%b r=%h want 001 0",
                      {bus.output_valid, bus.drop_err, bus.in_ready}, bus.r);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (bus.output_valid !== 1'b0) begin
        bad++; $display("FAIL midrst_quiet k=%0d got ov=%b want 0", k, bus.output_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_random();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
